// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the core data port, the fetch port and a boot loader.
// Core traffic is round-robin in RUN; a loader session stalls the core and drains reads around LOAD.
module mem_port_arbiter #(
  parameter int unsigned AW  = 14,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dm_req,
  input  logic          if_req,
  input  logic          ld_req,
  input  logic          dm_we,
  input  logic          ld_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [AW-1:0] if_addr,
  input  logic [AW-1:0] ld_addr,
  input  logic [3:0]    dm_be,
  input  logic [3:0]    ld_be,
  input  logic [DW-1:0] dm_wdata,
  input  logic [DW-1:0] ld_wdata,
  output logic          dm_gnt,
  output logic          if_gnt,
  output logic          ld_gnt,
  output logic          dm_rvalid,
  output logic          if_rvalid,
  output logic          ld_rvalid,
  output logic [DW-1:0] rdata,
  input  logic          ld_session,
  output logic          ld_active,
  output logic          core_hold,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {RUN, DRAIN_IN, LOAD, DRAIN_OUT} state_e;
  typedef enum logic [1:0] {PORT_DM, PORT_IF, PORT_LD} port_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [LAT-1:0]  pv_q;
  port_e           pid_q [LAT];
  logic            push;
  port_e           push_id;
  logic            pipe_empty;

  assign pipe_empty = ~|pv_q;

  // Grant decode, memory command mux and state/pointer next-state
  always_comb begin
    dm_gnt    = 1'b0;
    if_gnt    = 1'b0;
    ld_gnt    = 1'b0;
    state_d   = state_q;
    rr_d      = rr_q;
    core_hold = 1'b1;
    ld_active = 1'b0;
    unique case (state_q)
      RUN: begin
        core_hold = 1'b0;
        if (dm_req && (!if_req || !rr_q)) begin
          dm_gnt = 1'b1;
        end else if (if_req) begin
          if_gnt = 1'b1;
        end
        if (dm_gnt) begin
          rr_d = 1'b1;
        end else if (if_gnt) begin
          rr_d = 1'b0;
        end
        if (ld_session) state_d = DRAIN_IN;
      end
      DRAIN_IN: begin
        if (!ld_session)     state_d = RUN;
        else if (pipe_empty) state_d = LOAD;
      end
      LOAD: begin
        ld_active = 1'b1;
        ld_gnt    = ld_req;
        if (!ld_session) state_d = DRAIN_OUT;
      end
      DRAIN_OUT: begin
        if (pipe_empty) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem_en    = dm_gnt | if_gnt | ld_gnt;
    mem_we    = 1'b0;
    mem_addr  = if_addr;
    mem_be    = '0;
    mem_wdata = '0;
    push_id   = PORT_IF;
    if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_be    = dm_be;
      mem_wdata = dm_wdata;
      push_id   = PORT_DM;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_be    = ld_be;
      mem_wdata = ld_wdata;
      push_id   = PORT_LD;
    end
    push = mem_en && !mem_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Read tracker: stage 0 takes the granted read, stage LAT-1 is the response slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) pid_q[i] <= PORT_DM;
    end else begin
      pv_q[0]  <= push;
      pid_q[0] <= push_id;
      for (int unsigned i = 1; i < LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
    end
  end

  assign dm_rvalid = pv_q[LAT-1] && (pid_q[LAT-1] == PORT_DM);
  assign if_rvalid = pv_q[LAT-1] && (pid_q[LAT-1] == PORT_IF);
  assign ld_rvalid = pv_q[LAT-1] && (pid_q[LAT-1] == PORT_LD);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of per-cycle vectors plus hand-built reset/abort sequences.
module tb_mem_port_arbiter;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          dm_req, if_req, ld_req, dm_we, ld_we, ld_session;
  logic [AW-1:0] dm_addr, if_addr, ld_addr;
  logic [3:0]    dm_be, ld_be;
  logic [DW-1:0] dm_wdata, ld_wdata;
  logic          dm_gnt, if_gnt, ld_gnt, dm_rvalid, if_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic          ld_active, core_hold, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .dm_req(dm_req), .if_req(if_req), .ld_req(ld_req),
    .dm_we(dm_we), .ld_we(ld_we),
    .dm_addr(dm_addr), .if_addr(if_addr), .ld_addr(ld_addr),
    .dm_be(dm_be), .ld_be(ld_be),
    .dm_wdata(dm_wdata), .ld_wdata(ld_wdata),
    .dm_gnt(dm_gnt), .if_gnt(if_gnt), .ld_gnt(ld_gnt),
    .dm_rvalid(dm_rvalid), .if_rvalid(if_rvalid), .ld_rvalid(ld_rvalid),
    .rdata(rdata), .ld_session(ld_session), .ld_active(ld_active), .core_hold(core_hold),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory macro model with LAT-cycle read latency, byte-enabled writes
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [LAT];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rd_pipe[0] <= mem[mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // in  = {dm_req, dm_we, if_req, ld_req, ld_we, ld_session}
  // exp = {dm_gnt, if_gnt, ld_gnt, mem_en, dm_rvalid, if_rvalid, ld_rvalid, core_hold, ld_active}
  typedef struct {
    logic [5:0] in;
    logic [8:0] exp;
    logic       chk_rd;
  } vec_t;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  function automatic vec_t V(input logic [5:0] in, input logic [8:0] exp, input logic chk_rd);
    vec_t v;
    v.in = in; v.exp = exp; v.chk_rd = chk_rd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [8:0] act;
    {dm_req, dm_we, if_req, ld_req, ld_we, ld_session} = v.in;
    @(negedge clk);
    act = {dm_gnt, if_gnt, ld_gnt, mem_en, dm_rvalid, if_rvalid, ld_rvalid, core_hold, ld_active};
    n_vec++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", name, act, v.exp);
    end
    if (v.chk_rd) begin
      n_vec++;
      if (rdata !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL %s rdata: got %h expected deadbeef", name, rdata);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [34];

  initial begin
    reset = 1'b1;
    {dm_req, dm_we, if_req, ld_req, ld_we, ld_session} = '0;
    dm_addr = 14'h20; if_addr = 14'h30; ld_addr = 14'h10;
    dm_be = 4'hF; ld_be = 4'b1111;
    dm_wdata = 32'h12345678; ld_wdata = 32'hDEADBEEF;

    tbl[0]  = V(6'b000000, 9'b000000000, 1'b0); // reset state
    tbl[1]  = V(6'b101000, 9'b100100000, 1'b0); // both: dm first
    tbl[2]  = V(6'b101000, 9'b010100000, 1'b0);
    tbl[3]  = V(6'b101000, 9'b100110000, 1'b0);
    tbl[4]  = V(6'b101000, 9'b010101000, 1'b0);
    tbl[5]  = V(6'b101000, 9'b100110000, 1'b0);
    tbl[6]  = V(6'b101000, 9'b010101000, 1'b0);
    tbl[7]  = V(6'b000000, 9'b000010000, 1'b0);
    tbl[8]  = V(6'b000000, 9'b000001000, 1'b0);
    tbl[9]  = V(6'b001000, 9'b010100000, 1'b0); // fetch only, back to back
    tbl[10] = V(6'b001000, 9'b010100000, 1'b0);
    tbl[11] = V(6'b001000, 9'b010101000, 1'b0);
    tbl[12] = V(6'b001000, 9'b010101000, 1'b0);
    tbl[13] = V(6'b101000, 9'b100101000, 1'b0); // rr prefers data
    tbl[14] = V(6'b000000, 9'b000001000, 1'b0);
    tbl[15] = V(6'b000000, 9'b000010000, 1'b0);
    tbl[16] = V(6'b110000, 9'b100100000, 1'b0); // dm write: no rvalid later
    tbl[17] = V(6'b000000, 9'b000000000, 1'b0);
    tbl[18] = V(6'b000000, 9'b000000000, 1'b0);
    tbl[19] = V(6'b101000, 9'b010100000, 1'b0); // rr prefers fetch
    tbl[20] = V(6'b000100, 9'b000000000, 1'b0); // ld_req ignored in RUN
    tbl[21] = V(6'b000000, 9'b000001000, 1'b0);
    tbl[22] = V(6'b100000, 9'b100100000, 1'b0); // dm read in flight
    tbl[23] = V(6'b000001, 9'b000000000, 1'b0); // session raised
    tbl[24] = V(6'b101001, 9'b000010010, 1'b0); // DRAIN_IN, read returns
    tbl[25] = V(6'b101001, 9'b000000010, 1'b0);
    tbl[26] = V(6'b101111, 9'b001100011, 1'b0); // LOAD: write 0x10
    tbl[27] = V(6'b101101, 9'b001100011, 1'b0); // LOAD: read 0x10
    tbl[28] = V(6'b101000, 9'b000000011, 1'b0); // session dropped
    tbl[29] = V(6'b101000, 9'b000000110, 1'b1); // DRAIN_OUT, ld_rvalid
    tbl[30] = V(6'b101000, 9'b000000010, 1'b0);
    tbl[31] = V(6'b101000, 9'b010100000, 1'b0); // back in RUN
    tbl[32] = V(6'b000000, 9'b000000000, 1'b0);
    tbl[33] = V(6'b000000, 9'b000001000, 1'b0);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 34; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // ld_session pulse: DRAIN_IN falls back to RUN without LOAD
    apply(V(6'b000001, 9'b000000000, 1'b0), "abort_run");
    apply(V(6'b101000, 9'b000000010, 1'b0), "abort_drain");
    apply(V(6'b101000, 9'b100100000, 1'b0), "abort_back");
    apply(V(6'b000000, 9'b000000000, 1'b0), "abort_idle");
    apply(V(6'b000000, 9'b000010000, 1'b0), "abort_rv");

    // Two reads outstanding, rr left at 1, then a one-cycle reset
    apply(V(6'b001000, 9'b010100000, 1'b0), "rst_if");
    apply(V(6'b100000, 9'b100100000, 1'b0), "rst_dm");
    reset = 1'b1;
    apply(V(6'b000000, 9'b000000000, 1'b0), "rst_during");
    reset = 1'b0;
    apply(V(6'b000000, 9'b000000000, 1'b0), "rst_after1");
    apply(V(6'b000000, 9'b000000000, 1'b0), "rst_after2");
    apply(V(6'b101000, 9'b100100000, 1'b0), "rst_rr0");
    apply(V(6'b000000, 9'b000000000, 1'b0), "rst_idle");
    apply(V(6'b000000, 9'b000010000, 1'b0), "rst_newrv");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port iCE40 memory between the core's data port, its instruction-fetch port and an external program loader (UART/SPI boot path). It sits between the two-stage core and the memory macro. Data and fetch traffic are arbitrated round-robin while the core runs. A loader session stalls the core, drains in-flight reads, and hands the memory exclusively to the loader.

## Interface
- `AW`, 14, word-address width.
- `DW`, 32, data width.
- `LAT`, 1, memory read latency in cycles (legal 1..3).

- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dm_req`, `if_req`, `ld_req`  in  1 each  access request per port (data, fetch, loader).
- `dm_we`, `ld_we`  in  1 each  write enable (fetch is read-only).
- `dm_addr`, `if_addr`, `ld_addr`  in  AW each  word address.
- `dm_be`, `ld_be`  in  4 each  byte enables for writes.
- `dm_wdata`, `ld_wdata`  in  DW each  write data.
- `dm_gnt`, `if_gnt`, `ld_gnt`  out  1 each  request accepted this cycle.
- `dm_rvalid`, `if_rvalid`, `ld_rvalid`  out  1 each  read data valid for that port.
- `rdata`  out  DW  read data, shared by all ports, qualified by the rvalid strobes.
- `ld_session`  in  1  loader requests exclusive ownership.
- `ld_active`  out  1  loader owns the memory.
- `core_hold`  out  1  core must freeze its PC and pipeline.
- `mem_en`, `mem_we`  out  1 each  memory strobe and write enable.
- `mem_addr`  out  AW  memory address.
- `mem_be`  out  4  memory byte enables.
- `mem_wdata`  out  DW  memory write data.
- `mem_rdata`  in  DW  memory read data, valid LAT cycles after a read strobe.

## Operation
- States:
  - RUN: core ports arbitrated; `ld_req` is ignored.
  - DRAIN_IN: no grants; waits for the read pipeline to empty.
  - LOAD: only `ld_req` is granted.
  - DRAIN_OUT: no grants; waits for loader reads to complete.
- Transitions:
  - RUN → DRAIN_IN when `ld_session`=1.
  - DRAIN_IN → LOAD when the pipeline is empty and `ld_session`=1.
  - DRAIN_IN → RUN when `ld_session`=0, checked first.
  - LOAD → DRAIN_OUT when `ld_session`=0.
  - DRAIN_OUT → RUN when the pipeline is empty.
- `core_hold`=1 in DRAIN_IN, LOAD and DRAIN_OUT. `ld_active`=1 only in LOAD.
- Round-robin in RUN uses a 1-bit pointer `rr`: 0 prefers data, 1 prefers fetch.
  - If both request, the preferred port is granted.
  - If one requests, it is granted.
  - After any grant, `rr` points to the other port.
  - `rr` is not updated when nothing is granted.
- At most one `*_gnt` is high per cycle. The grant is combinational from the requests, the state and `rr`.
- The `mem_*` command is driven combinationally from the granted port. `mem_en`=0 when nothing is granted; the other `mem_*` outputs are then don't-care.
- Requesters hold request, address and data stable until granted. A request dropped before grant is legal and has no effect.
- Read tracking: a LAT-deep shift register of {valid, port id} is pushed on every granted read; writes push nothing. The stage-LAT entry drives the `*_rvalid` strobes.
- "Pipeline empty" means all shift-register entries are invalid.
- `rdata` = `mem_rdata`, passed through combinationally.

## Timing
- Grant and memory strobe occur in the same cycle as the request when the port is eligible.
- Read data: the `*_rvalid` pulse comes exactly LAT cycles after the granted read, one cycle wide.
- Back-to-back grants are allowed every cycle: one access per cycle.
- Minimum RUN → LOAD: 1 cycle (DRAIN_IN) plus the remaining in-flight latency. With an idle pipeline, `ld_session` rising at cycle n gives `ld_active`=1 at cycle n+2.
- A read granted in the last RUN cycle still delivers its `rvalid` during DRAIN_IN.
- Reset values: state RUN, `rr`=0, shift register all invalid. All `*_rvalid`, `ld_active` and `core_hold` are 0. With no requests, all `*_gnt` and `mem_en` are 0.
- Reset asserted mid-transfer: pending reads are discarded and no `rvalid` is produced for them.
- `ld_session` toggling in DRAIN_IN returns to RUN without entering LOAD.

## Test plan
- Data and fetch both request every cycle for 6 cycles from reset → grants alternate dm, if, dm, if, dm, if; each read produces its `rvalid` exactly LAT cycles later on the correct port.
- Only `if_req` held with LAT=2 → `if_gnt`=1 every cycle and `if_rvalid` continuous from the 3rd cycle; `rr` then prefers data, so a later simultaneous request grants dm first.
- `ld_session` raised while a data read is in flight (LAT=3) → `core_hold`=1 the next cycle with no grants; the `dm_rvalid` still arrives; `ld_active`=1 once the pipeline is empty.
- In LOAD, write 0xDEADBEEF with `ld_be`=4'b1111 to address 0x10, then read 0x10 → `ld_rvalid` with `rdata`=0xDEADBEEF. `dm_req`/`if_req` held high throughout are never granted.
- Drop `ld_session` during a loader read → DRAIN_OUT until its `ld_rvalid`, then RUN with `core_hold`=0 the following cycle.
- Assert `reset` for 1 cycle with 2 reads outstanding → no `rvalid` afterwards, state RUN, `rr`=0.
